// File: rtl/quad_step_decoder.sv
// quad_step_decoder
//   Quadrature (A/B) encoder decoder. Synchronizes the two asynchronous
//   encoder phases and recovers the direction and the step events. It keeps
//   a WIDTH-bit up/down position count and flags illegal phase jumps.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous, active-low reset
//   qa, qb     encoder phases A and B (asynchronous)
//   en         decode enable; when low, no count/step/wrap/err activity
//   clr        synchronous clear of count and err_sticky
//   count      current position, wraps modulo 2^WIDTH
//   dir        direction of the last legal step (1 = up, 0 = down)
//   step       one-cycle pulse per legal transition
//   wrap       one-cycle pulse when count wraps in either direction
//   err        one-cycle pulse on an illegal (both-bits-changed) transition
//   err_sticky set by err, held until clr or reset
module quad_step_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qa,
  input  logic             qb,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err,
  output logic             err_sticky
);

  localparam int PW = $clog2(SYNC_STAGES + 2);

  typedef enum logic {
    PRIME,
    RUN
  } stateT;

  stateT                  state;
  stateT                  nextState;
  logic [PW-1:0]          primeCnt;
  logic [SYNC_STAGES-1:0] syncA;
  logic [SYNC_STAGES-1:0] syncB;
  logic [1:0]             syncNow;
  logic [1:0]             prev;
  logic [1:0]             phaseDelta;
  logic                   decodeActive;
  logic                   isUp;
  logic                   isDown;
  logic                   isErr;

  // Position of a phase pair along the up sequence 00 -> 10 -> 11 -> 01.
  // The difference of two positions (mod 4) tells the kind of transition:
  // 1 is one step up, 3 is one step down, 2 means both bits jumped.
  function automatic logic [1:0] phasePos(input logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      2'b00:   pos = 2'd0;
      2'b10:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

  // Shift-register synchronizers for both phases; the last stage is the
  // value the decoder trusts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= {syncA[SYNC_STAGES-2:0], qa};
      syncB <= {syncB[SYNC_STAGES-2:0], qb};
    end
  end

  assign syncNow = {syncA[SYNC_STAGES-1], syncB[SYNC_STAGES-1]};

  // The previous synchronized phase pair always tracks, even while priming
  // or disabled, so re-enabling never produces a catch-up step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev <= 2'b00;
    end else begin
      prev <= syncNow;
    end
  end

  // State register for the priming sequencer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= PRIME;
    end else begin
      state <= nextState;
    end
  end

  // Priming lasts SYNC_STAGES+1 cycles after reset release: long enough for
  // the synchronizer and prev to fill with the real input level, so an
  // input held at 11 through reset is not mistaken for an illegal jump.
  always_comb begin
    nextState = state;
    case (state)
      PRIME:   if (primeCnt == PW'(SYNC_STAGES)) nextState = RUN;
      RUN:     nextState = RUN;
      default: nextState = PRIME;
    endcase
  end

  // Cycle counter that paces the priming window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      primeCnt <= '0;
    end else if (state == PRIME) begin
      primeCnt <= primeCnt + PW'(1);
    end
  end

  // Transition classification between prev and the current synchronized pair.
  always_comb begin
    phaseDelta   = phasePos(syncNow) - phasePos(prev);
    decodeActive = (state == RUN) && en;
    isUp         = decodeActive && (phaseDelta == 2'd1);
    isDown       = decodeActive && (phaseDelta == 2'd3);
    isErr        = decodeActive && (phaseDelta == 2'd2);
  end

  // Registered outputs. Pulses default low every cycle. clr wins over a
  // step on the same cycle, but an illegal jump still pulses err while
  // err_sticky is being cleared. dir records the legal step even when clr
  // suppresses the count change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= '0;
      dir        <= 1'b1;
      step       <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      if (isUp) begin
        dir <= 1'b1;
        if (!clr) begin
          count <= count + WIDTH'(1);
          step  <= 1'b1;
          wrap  <= (count == '1);
        end
      end else if (isDown) begin
        dir <= 1'b0;
        if (!clr) begin
          count <= count - WIDTH'(1);
          step  <= 1'b1;
          wrap  <= (count == '0);
        end
      end else if (isErr) begin
        err        <= 1'b1;
        err_sticky <= 1'b1;
      end
      if (clr) begin
        count      <= '0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder
//   Directed bench for quad_step_decoder. A behavioural model recomputes the
//   expected outputs every clock from the raw input history; a compare
//   process checks every output on every falling edge, and literal
//   expectations pin the model at the key points of each scenario.
module tb_quad_step_decoder;

  localparam int WIDTH = 4;
  localparam int SS    = 2;
  localparam int MOD   = 1 << WIDTH;

  logic             clk;
  logic             rst;
  logic             qa;
  logic             qb;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             step;
  logic             wrap;
  logic             err;
  logic             err_sticky;

  int checks   = 0;
  int failures = 0;
  int stepSeen = 0;
  int wrapSeen = 0;
  int errSeen  = 0;

  // Model state
  bit         modelValid = 1'b0;
  int         mCount;
  bit         mDir;
  bit         mStep;
  bit         mWrap;
  bit         mErr;
  bit         mSticky;
  int         sinceRel;
  logic [1:0] hist [1:6];
  logic [1:0] upSeq [4];

  quad_step_decoder #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .qa        (qa),
    .qb        (qb),
    .en        (en),
    .clr       (clr),
    .count     (count),
    .dir       (dir),
    .step      (step),
    .wrap      (wrap),
    .err       (err),
    .err_sticky(err_sticky)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic compare used by both the per-cycle checker and literal checks
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one input vector (from a falling edge) and hold it for some cycles
  task automatic applyStimulus(input logic a, input logic b, input logic e,
                               input logic c, input logic r, input int cycles);
    qa  = a;
    qb  = b;
    en  = e;
    clr = c;
    rst = r;
    repeat (cycles) @(negedge clk);
  endtask

  // Behavioural model: the decoder sees the raw input sampled SS edges ago,
  // compared to the one sampled SS+1 edges ago; decoding is suppressed for
  // the first SS+1 edges after reset release.
  always @(posedge clk) begin
    logic [1:0] sOld;
    logic [1:0] sNew;
    bit         up;
    bit         down;
    if (!rst) begin
      mCount     = 0;
      mDir       = 1'b1;
      mStep      = 1'b0;
      mWrap      = 1'b0;
      mErr       = 1'b0;
      mSticky    = 1'b0;
      sinceRel   = 0;
      modelValid = 1'b1;
      for (int k = 1; k <= 6; k++) hist[k] = 2'b00;
    end else begin
      sNew  = hist[SS];
      sOld  = hist[SS+1];
      mStep = 1'b0;
      mWrap = 1'b0;
      mErr  = 1'b0;
      up    = 1'b0;
      down  = 1'b0;
      if (sinceRel < SS + 2) sinceRel++;
      for (int i = 0; i < 4; i++) begin
        if (sOld == upSeq[i] && sNew == upSeq[(i+1)%4]) up = 1'b1;
        if (sNew == upSeq[i] && sOld == upSeq[(i+1)%4]) down = 1'b1;
      end
      if (sinceRel >= SS + 2 && en && sOld != sNew) begin
        if (up) begin
          mDir = 1'b1;
          if (!clr) begin
            mCount = (mCount + 1) % MOD;
            mStep  = 1'b1;
            mWrap  = (mCount == 0);
          end
        end else if (down) begin
          mDir = 1'b0;
          if (!clr) begin
            mWrap  = (mCount == 0);
            mCount = (mCount + MOD - 1) % MOD;
            mStep  = 1'b1;
          end
        end else begin
          mErr    = 1'b1;
          mSticky = 1'b1;
        end
      end
      if (clr) begin
        mCount  = 0;
        mSticky = 1'b0;
      end
      for (int k = 6; k >= 2; k--) hist[k] = hist[k-1];
      hist[1] = {qa, qb};
    end
  end

  // Per-cycle compare against the model, plus pulse tallies for literal checks
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("count", 32'(count), 32'(mCount));
      checkOutput("dir", 32'(dir), 32'(mDir));
      checkOutput("step", 32'(step), 32'(mStep));
      checkOutput("wrap", 32'(wrap), 32'(mWrap));
      checkOutput("err", 32'(err), 32'(mErr));
      checkOutput("err_sticky", 32'(err_sticky), 32'(mSticky));
      if (step === 1'b1) stepSeen++;
      if (wrap === 1'b1) wrapSeen++;
      if (err === 1'b1) errSeen++;
    end
  end

  initial begin
    upSeq[0] = 2'b00;
    upSeq[1] = 2'b10;
    upSeq[2] = 2'b11;
    upSeq[3] = 2'b01;
    qa  = 1'b1;
    qb  = 1'b1;
    en  = 1'b1;
    clr = 1'b0;
    rst = 1'b0;

    // 1: reset with inputs at 11, release and hold
    $display("[TB] scenario 1: reset with inputs high");
    repeat (3) @(negedge clk);
    #1;
    stepSeen = 0;
    errSeen  = 0;
    applyStimulus(1, 1, 1, 0, 1, 8);
    #1;
    checkOutput("s1_count", 32'(count), 32'd0);
    checkOutput("s1_sticky", 32'(err_sticky), 32'd0);
    checkOutput("s1_steps", 32'(stepSeen), 32'd0);
    checkOutput("s1_errs", 32'(errSeen), 32'd0);

    // Walk down to 00, clear, then 4 up steps with a latency probe
    $display("[TB] scenario 2: four up steps");
    applyStimulus(1, 0, 1, 0, 1, 4);
    applyStimulus(0, 0, 1, 0, 1, 4);
    applyStimulus(0, 0, 1, 1, 1, 1);
    applyStimulus(1, 0, 1, 0, 1, 2);
    #1;
    checkOutput("s2_lat_early", 32'(step), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("s2_lat_step", 32'(step), 32'd1);
    checkOutput("s2_lat_count", 32'(count), 32'd1);
    @(negedge clk);
    applyStimulus(1, 1, 1, 0, 1, 4);
    applyStimulus(0, 1, 1, 0, 1, 4);
    applyStimulus(0, 0, 1, 0, 1, 4);
    #1;
    checkOutput("s2_count", 32'(count), 32'd4);
    checkOutput("s2_dir", 32'(dir), 32'd1);

    // 3: from count 1, three down steps through the wrap
    $display("[TB] scenario 3: down steps with wrap");
    applyStimulus(0, 0, 1, 1, 1, 1);
    applyStimulus(1, 0, 1, 0, 1, 4);
    #1;
    checkOutput("s3_start", 32'(count), 32'd1);
    wrapSeen = 0;
    applyStimulus(0, 0, 1, 0, 1, 4);
    applyStimulus(0, 1, 1, 0, 1, 4);
    applyStimulus(1, 1, 1, 0, 1, 4);
    #1;
    checkOutput("s3_count", 32'(count), 32'd14);
    checkOutput("s3_dir", 32'(dir), 32'd0);
    checkOutput("s3_wraps", 32'(wrapSeen), 32'd1);

    // 4: illegal 00 -> 11 jump, then clear
    $display("[TB] scenario 4: illegal jump and clear");
    applyStimulus(1, 0, 1, 0, 1, 4);
    applyStimulus(0, 0, 1, 0, 1, 4);
    #1;
    errSeen = 0;
    applyStimulus(1, 1, 1, 0, 1, 4);
    #1;
    checkOutput("s4_errs", 32'(errSeen), 32'd1);
    checkOutput("s4_sticky", 32'(err_sticky), 32'd1);
    checkOutput("s4_count", 32'(count), 32'd12);
    applyStimulus(1, 1, 1, 1, 1, 1);
    applyStimulus(1, 1, 1, 0, 1, 2);
    #1;
    checkOutput("s4_clr_count", 32'(count), 32'd0);
    checkOutput("s4_clr_sticky", 32'(err_sticky), 32'd0);

    // 5: disabled steps are ignored, the next enabled step counts once
    $display("[TB] scenario 5: enable gating");
    stepSeen = 0;
    applyStimulus(0, 1, 0, 0, 1, 4);
    applyStimulus(0, 0, 0, 0, 1, 4);
    applyStimulus(0, 0, 1, 0, 1, 4);
    #1;
    checkOutput("s5_count_off", 32'(count), 32'd0);
    checkOutput("s5_steps_off", 32'(stepSeen), 32'd0);
    applyStimulus(1, 0, 1, 0, 1, 4);
    #1;
    checkOutput("s5_count_on", 32'(count), 32'd1);
    checkOutput("s5_steps_on", 32'(stepSeen), 32'd1);

    // 6: reset pulse mid-sequence at count 7, then a quiet priming window
    $display("[TB] scenario 6: reset mid-sequence");
    applyStimulus(1, 1, 1, 0, 1, 4);
    applyStimulus(0, 1, 1, 0, 1, 4);
    applyStimulus(0, 0, 1, 0, 1, 4);
    applyStimulus(1, 0, 1, 0, 1, 4);
    applyStimulus(1, 1, 1, 0, 1, 4);
    applyStimulus(0, 1, 1, 0, 1, 4);
    #1;
    checkOutput("s6_count7", 32'(count), 32'd7);
    applyStimulus(0, 1, 1, 0, 0, 1);
    #1;
    stepSeen = 0;
    errSeen  = 0;
    applyStimulus(0, 1, 1, 0, 1, SS + 1);
    #1;
    checkOutput("s6_count", 32'(count), 32'd0);
    checkOutput("s6_dir", 32'(dir), 32'd1);
    checkOutput("s6_steps", 32'(stepSeen), 32'd0);
    checkOutput("s6_errs", 32'(errSeen), 32'd0);
    applyStimulus(0, 1, 1, 0, 1, 4);
    applyStimulus(0, 0, 1, 0, 1, 4);
    #1;
    checkOutput("s6_after", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
